// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, instruction memory with a program-load port,
// and a RST/FETCH/WAIT sequencer. Define FETCH_ALIGN_TRAP_EN to trap misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_update,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic               jr_en,
  input  logic [31:0]        jr_target,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic               fetch_fault,
  output logic [1:0]         fsm_state
);

  // Handshake: instr_valid pulses once when instr is loaded; the consumer then
  // raises pc_update (level, sampled only in WAIT) to retire it and advance the PC.
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
`ifdef FETCH_ALIGN_TRAP_EN
    , S_FAULT = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] imem [0:(1<<IMEM_AW)-1];
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign opcode     = instr[31:26];
  assign fsm_state  = state;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr_en)
      next_pc = jr_target;
    else if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && alu_zero)
      next_pc = pc_plus4 + branch_off;
  end

  // Memory has no reset so a loaded program survives reset pulses.
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

`ifndef FETCH_ALIGN_TRAP_EN
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH: begin
          // Non-blocking read returns pre-write data on a same-cycle load-port write.
          instr       <= imem[pc[IMEM_AW+1:2]];
          instr_valid <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (pc_update) begin
`ifdef FETCH_ALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= S_FAULT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
`else
            pc    <= next_pc & 32'hFFFF_FFFC;
            state <= S_FETCH;
`endif
          end
        end
`ifdef FETCH_ALIGN_TRAP_EN
        S_FAULT: state <= S_FAULT;
`endif
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch sequencing, branch/jump/jr redirects,
// PC wraparound, write/read collision, misaligned targets and asynchronous reset.
module tb_fetch_unit;

  localparam logic [1:0] ST_RST = 2'd0, ST_FETCH = 2'd1, ST_WAIT = 2'd2, ST_FAULT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_update, jump, branch, alu_zero, jr_en;
  logic [31:0] jr_target;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  opcode;
  logic        instr_valid, fetch_fault;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
    .clk(clk), .reset(reset), .pc_update(pc_update), .jump(jump), .branch(branch),
    .alu_zero(alu_zero), .jr_en(jr_en), .jr_target(jr_target), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Caller sets redirect qualifiers first; the task retires the current instruction.
  task automatic do_update(input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                           input bit chk_instr, input string name);
    @(negedge clk);
    pc_update = 1'b1;
    @(negedge clk);
    pc_update = 1'b0; jr_en = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    vectors++;
    if (pc !== exp_pc) begin
      miscompares++;
      $display("FAIL %s pc: got %h expected %h", name, pc, exp_pc);
    end
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s instr_valid: got %b expected 1", name, instr_valid);
    end
    if (chk_instr) begin
      vectors++;
      if (instr !== exp_instr) begin
        miscompares++;
        $display("FAIL %s instr: got %h expected %h", name, instr, exp_instr);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    write_word(8'd0, 32'h2000_0000);
    write_word(8'd1, 32'h8C00_0004);
    write_word(8'd2, 32'h0000_0000);
    write_word(8'd3, 32'h0000_0000);
    write_word(8'd4, 32'h1000_FFFE);
    write_word(8'd5, 32'h0000_0000);
    write_word(8'd8, 32'h0810_0040);
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL reset pc: got %h expected 0", pc); end
    vectors++;
    if (instr !== 32'h0) begin miscompares++; $display("FAIL reset instr: got %h expected 0", instr); end
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset instr_valid: got %b expected 0", instr_valid); end
    vectors++;
    if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset fetch_fault: got %b expected 0", fetch_fault); end
    vectors++;
    if (fsm_state !== ST_RST) begin miscompares++; $display("FAIL reset state: got %0d expected %0d", fsm_state, ST_RST); end
    vectors++;
    if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset pc_plus4: got %h expected 4", pc_plus4); end
  endtask

  // pc_update is held high through RST and FETCH to show it is ignored there.
  task automatic test_fetch_sequence();
    @(negedge clk);
    reset = 1'b0; pc_update = 1'b1;
    @(negedge clk);
    vectors++;
    if (fsm_state !== ST_FETCH) begin miscompares++; $display("FAIL seq state_fetch: got %0d expected %0d", fsm_state, ST_FETCH); end
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL seq pc_in_fetch: got %h expected 0", pc); end
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL seq first_valid: got %b expected 1", instr_valid); end
    vectors++;
    if (instr !== 32'h2000_0000) begin miscompares++; $display("FAIL seq first_instr: got %h expected 20000000", instr); end
    vectors++;
    if (opcode !== 6'h08) begin miscompares++; $display("FAIL seq opcode: got %h expected 08", opcode); end
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL seq pc_ignored: got %h expected 0", pc); end
    pc_update = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq valid_pulse: got %b expected 0", instr_valid); end
    vectors++;
    if (fsm_state !== ST_WAIT || pc !== 32'h0) begin
      miscompares++; $display("FAIL seq wait_hold: got state %0d pc %h expected state 2 pc 0", fsm_state, pc);
    end
    do_update(32'h4, 32'h8C00_0004, 1'b1, "seq second");
  endtask

  task automatic test_branch();
    do_update(32'h8, 32'h0, 1'b1, "br walk8");
    do_update(32'hC, 32'h0, 1'b1, "br walkC");
    do_update(32'h10, 32'h1000_FFFE, 1'b1, "br walk10");
    branch = 1'b1; alu_zero = 1'b1;
    do_update(32'hC, 32'h0, 1'b1, "br taken");
    do_update(32'h10, 32'h1000_FFFE, 1'b1, "br back10");
    branch = 1'b1; alu_zero = 1'b0;
    do_update(32'h14, 32'h0, 1'b1, "br not_taken");
  endtask

  task automatic test_collision();
    jr_en = 1'b1; jr_target = 32'h14;
    @(negedge clk);
    pc_update = 1'b1;
    @(negedge clk);
    pc_update = 1'b0; jr_en = 1'b0;
    imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_we = 1'b0;
    vectors++;
    if (instr !== 32'h0) begin miscompares++; $display("FAIL collide old_data: got %h expected 0", instr); end
    jr_en = 1'b1; jr_target = 32'h14;
    do_update(32'h14, 32'hDEAD_BEEF, 1'b1, "collide new_data");
  endtask

  task automatic test_jump();
    jr_en = 1'b1; jr_target = 32'h0040_0020;
    do_update(32'h0040_0020, 32'h0810_0040, 1'b1, "jmp jr_load");
    vectors++;
    if (opcode !== 6'h02) begin miscompares++; $display("FAIL jmp opcode: got %h expected 02", opcode); end
    jump = 1'b1;
    do_update(32'h0040_0100, 32'h0, 1'b0, "jmp target");
    jr_en = 1'b1; jr_target = 32'h0040_0020;
    do_update(32'h0040_0020, 32'h0810_0040, 1'b1, "jmp reload");
    jump = 1'b1; jr_en = 1'b1; jr_target = 32'h80;
    do_update(32'h80, 32'h0, 1'b0, "jmp jr_priority");
  endtask

  task automatic test_wrap();
    jr_en = 1'b1; jr_target = 32'hFFFF_FFFC;
    do_update(32'hFFFF_FFFC, 32'h0, 1'b0, "wrap top");
    vectors++;
    if (pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap pc_plus4: got %h expected 0", pc_plus4); end
    do_update(32'h0, 32'h2000_0000, 1'b1, "wrap zero");
  endtask

  task automatic test_misaligned();
    bit saw_valid;
    jr_en = 1'b1; jr_target = 32'h0000_0006;
`ifdef FETCH_ALIGN_TRAP_EN
    @(negedge clk);
    pc_update = 1'b1;
    @(negedge clk);
    pc_update = 1'b0; jr_en = 1'b0;
    vectors++;
    if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL align fault: got %b expected 1", fetch_fault); end
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL align pc_hold: got %h expected 0", pc); end
    vectors++;
    if (fsm_state !== ST_FAULT) begin miscompares++; $display("FAIL align state: got %0d expected %0d", fsm_state, ST_FAULT); end
    saw_valid = 1'b0;
    pc_update = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) saw_valid = 1'b1;
    end
    pc_update = 1'b0;
    vectors++;
    if (saw_valid) begin miscompares++; $display("FAIL align no_fetch: got instr_valid 1 expected 0"); end
`else
    saw_valid = 1'b0;
    do_update(32'h4, 32'h8C00_0004, 1'b1, "align forced");
    vectors++;
    if (fetch_fault !== saw_valid) begin miscompares++; $display("FAIL align fault_tied: got %b expected 0", fetch_fault); end
`endif
  endtask

  task automatic test_async_reset();
    bit found;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; pc_update = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fsm_state == ST_WAIT && instr_valid == 1'b1 && pc == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL areset reach_wait: got timeout expected WAIT at pc 4"); end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("FAIL areset pc: got %h expected 0", pc); end
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL areset valid: got %b expected 0", instr_valid); end
    vectors++;
    if (instr !== 32'h0 || fsm_state !== ST_RST) begin
      miscompares++; $display("FAIL areset instr_state: got %h/%0d expected 0/0", instr, fsm_state);
    end
    @(negedge clk);
    pc_update = 1'b0; reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h2000_0000) begin
      miscompares++;
      $display("FAIL areset refetch: got valid %b pc %h instr %h expected 1 0 20000000", instr_valid, pc, instr);
    end
  endtask

  initial begin
    reset = 1'b1; pc_update = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    jr_en = 1'b0; jr_target = 32'h0; imem_we = 1'b0; imem_waddr = 8'h0; imem_wdata = 32'h0;
    test_reset();
    test_fetch_sequence();
    test_branch();
    test_collision();
    test_jump();
    test_wrap();
    test_misaligned();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
